x_mod_47_seq_ctrl: RTL

//  Iterative sequencer that reduces a wide operand X modulo 47 through one narrow chunk reducer, reused every cycle.

---
 rtl/x_mod_47_seq_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/x_mod_47_seq_ctrl.sv
// x_mod_47_seq_ctrl: iterative X mod 47. A WIDTH-bit operand is consumed one
// CHUNK-bit slice per cycle, MSB first, through a single folding reducer.
// Optional build macro: MOD47_ZERO_SKIP_EN skips leading all-zero chunks on accept.
module x_mod_47_seq_ctrl #(
  parameter int WIDTH   = 300,
  parameter int CHUNK   = 60,
  parameter int MODULUS = 47
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       R,
  output logic             busy
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int LW     = $clog2(NCHUNK + 1);
  localparam int NDIG   = (CHUNK + 5) / 6;

  // 2^n mod MODULUS, evaluated at elaboration only
  function automatic int pow2_mod(input int n);
    int p;
    p = 1 % MODULUS;
    for (int i = 0; i < n; i++) p = (p * 2) % MODULUS;
    return p;
  endfunction

  localparam logic [15:0] W64 = 16'(pow2_mod(6));      // weight of a 6-bit digit step
  localparam logic [15:0] P2C = 16'(pow2_mod(CHUNK));  // 2^CHUNK mod 47 (28 at default)

  // Refold a 16-bit value in base 64 (64 == 17 mod 47). Seven folds bring any
  // 16-bit input to <= 80, so a single conditional subtract lands in 0..46.
  function automatic logic [5:0] fold47(input logic [15:0] x);
    logic [15:0] t;
    t = x;
    for (int i = 0; i < 7; i++)
      t = {10'd0, t[5:0]} + {6'd0, t[15:6]} * W64;
    if (t >= 16'(MODULUS)) t = t - 16'(MODULUS);
    return t[5:0];
  endfunction

  // Chunk residue: 6-bit digits weighted by 2^(6i) mod 47, summed, then refolded
  function automatic logic [5:0] chunk_mod47(input logic [CHUNK-1:0] c);
    logic [NDIG*6-1:0] cp;
    logic [15:0]       s;
    cp = '0;
    cp[CHUNK-1:0] = c;
    s = '0;
    for (int i = 0; i < NDIG; i++)
      s = s + {10'd0, cp[6*i +: 6]} * 16'(pow2_mod(6 * i));
    return fold47(s);
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sreg;
  logic [5:0]       acc, acc_nx;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             load_zero;
  logic [WIDTH-1:0] load_sreg;
  logic [CW-1:0]    load_cnt;

  assign last   = (cnt == CW'(NCHUNK - 1));
  assign acc_nx = fold47(16'(acc) * P2C + {10'd0, chunk_mod47(sreg[WIDTH-1 -: CHUNK])});

`ifdef MOD47_ZERO_SKIP_EN
  logic [LW-1:0] lz;
  logic          seen;

  // Count leading all-zero chunks of the incoming operand
  always_comb begin
    lz   = '0;
    seen = 1'b0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (!seen && X[WIDTH-1-i*CHUNK -: CHUNK] == '0) lz = lz + LW'(1);
      else seen = 1'b1;
    end
  end

  assign load_zero = (lz == LW'(NCHUNK));
  assign load_sreg = X << (lz * CHUNK);
  assign load_cnt  = load_zero ? '0 : CW'(lz);
`else
  assign load_zero = 1'b0;
  assign load_sreg = X;
  assign load_cnt  = '0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next state and handshake outputs
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    R         = '0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nx = load_zero ? S_DONE : S_RUN;
      end
      S_RUN:  if (last) state_nx = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        R         = acc;
        if (out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand shift register, accumulator and chunk counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg <= '0;
      acc  <= '0;
      cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          sreg <= load_sreg;
          acc  <= '0;
          cnt  <= load_cnt;
        end
        S_RUN: begin
          acc  <= acc_nx;
          sreg <= sreg << CHUNK;
          cnt  <= last ? '0 : cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule
